// File: rtl/reg_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_write_arbiter_pkg
// Purpose  : Shared defaults and FSM state encoding for the register write
//            arbiter and its round-robin picker.
// Revision : 1.0 - initial release
// ============================================================================
package reg_write_arbiter_pkg;

    // Default geometry of the write path
    localparam int c_WIDTH_DEF = 16;
    localparam int c_NREQ_DEF  = 3;
    localparam int c_NREG_DEF  = 4;

    // Each requester addresses its target register with a 2-bit index
    localparam int c_ADDR_W    = 2;

    // Two-state write FSM
    localparam int                  c_STATE_W = 1;
    localparam logic [c_STATE_W-1:0] c_S_IDLE  = 1'b0;
    localparam logic [c_STATE_W-1:0] c_S_WRITE = 1'b1;

    // Index width that stays at least one bit for a single requester
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_write_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin choice. The scan starts one past the
//            previous winner and wraps, so the previous winner has the lowest
//            priority this round.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick
    import reg_write_arbiter_pkg::*;
#(
    parameter int NREQ = c_NREQ_DEF,
    parameter int IDXW = idx_width(c_NREQ_DEF)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDXW-1:0] i_last_winner,
    output logic            o_valid,
    output logic [IDXW-1:0] o_winner
);

    int w_dist;
    int w_best;

    // Winner is the requesting index with the smallest distance after last_winner
    always_comb begin
        o_valid  = 1'b0;
        o_winner = '0;
        w_dist   = 0;
        w_best   = NREQ;
        for (int k = 0; k < NREQ; k++) begin
            w_dist = (k - int'(i_last_winner) - 1 + 2 * NREQ) % NREQ;
            if (i_req[k] && (w_dist < w_best)) begin
                w_best   = w_dist;
                o_valid  = 1'b1;
                o_winner = IDXW'(k);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/reg_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : reg_write_arbiter
// Purpose  : Round-robin arbiter that lets several requesters write a bank of
//            external load-enabled registers over one shared data bus. A write
//            takes an arbitration edge plus one WRITE cycle; all outputs are
//            registered.
// Revision : 1.0 - initial release
// ============================================================================
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter int WIDTH = c_WIDTH_DEF,
    parameter int NREQ  = c_NREQ_DEF,
    parameter int NREG  = c_NREG_DEF
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*2-1:0]      addr,
    input  logic [NREQ*WIDTH-1:0]  wdata,
    output logic [NREQ-1:0]        gnt,
    output logic [NREG-1:0]        reg_load,
    output logic [WIDTH-1:0]       reg_in,
    output logic                   busy,
    output logic [7:0]             wr_count
);

    localparam int IDXW = idx_width(NREQ);

    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_state_nxt;
    logic [IDXW-1:0]      r_last;
    logic                 w_valid;
    logic [IDXW-1:0]      w_winner;
    logic                 w_arb;
    logic [c_ADDR_W-1:0]  w_addr_sel;
    logic [WIDTH-1:0]     w_data_sel;
    logic [NREQ-1:0]      w_gnt_nxt;
    logic [NREG-1:0]      w_load_nxt;
    logic [WIDTH-1:0]     w_reg_in_nxt;
    logic                 w_busy_nxt;
    logic [NREQ-1:0]      r_gnt;
    logic [NREG-1:0]      r_load;
    logic [WIDTH-1:0]     r_reg_in;
    logic                 r_busy;
    logic [7:0]           r_count;

    rr_pick #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_rr_pick (
        .i_req         (req),
        .i_last_winner (r_last),
        .o_valid       (w_valid),
        .o_winner      (w_winner)
    );

    // Arbitration only happens from IDLE; WRITE always lasts a single cycle
    assign w_arb = (r_state == c_S_IDLE) && w_valid;

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = c_S_IDLE;
        if (r_state == c_S_IDLE) begin
            w_state_nxt = w_valid ? c_S_WRITE : c_S_IDLE;
        end
    end

    // Select the winning requester's address and data
    always_comb begin
        w_addr_sel = '0;
        w_data_sel = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (int'(w_winner) == k) begin
                w_addr_sel = addr[c_ADDR_W*k +: c_ADDR_W];
                w_data_sel = wdata[WIDTH*k +: WIDTH];
            end
        end
    end

    // Output decode: values to be registered for the coming WRITE cycle
    always_comb begin
        w_gnt_nxt    = '0;
        w_load_nxt   = '0;
        w_reg_in_nxt = '0;
        w_busy_nxt   = 1'b0;
        if (w_arb) begin
            for (int k = 0; k < NREQ; k++) begin
                if (int'(w_winner) == k) begin
                    w_gnt_nxt[k] = 1'b1;
                end
            end
            // Indices beyond the register bank load nothing
            for (int k = 0; k < NREG; k++) begin
                if (int'(w_addr_sel) == k) begin
                    w_load_nxt[k] = 1'b1;
                end
            end
            w_reg_in_nxt = w_data_sel;
            w_busy_nxt   = 1'b1;
        end
    end

    // Output registers, write counter and round-robin pointer
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_gnt    <= '0;
            r_load   <= '0;
            r_reg_in <= '0;
            r_busy   <= 1'b0;
            r_count  <= '0;
            r_last   <= IDXW'(NREQ - 1);
        end else begin
            r_gnt    <= w_gnt_nxt;
            r_load   <= w_load_nxt;
            r_reg_in <= w_reg_in_nxt;
            r_busy   <= w_busy_nxt;
            if (r_state == c_S_WRITE) begin
                r_count <= r_count + 8'd1;
            end
            if (w_arb) begin
                r_last <= w_winner;
            end
        end
    end

    assign gnt      = r_gnt;
    assign reg_load = r_load;
    assign reg_in   = r_reg_in;
    assign busy     = r_busy;
    assign wr_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_reg_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_write_arbiter
// Purpose  : Self-checking bench for reg_write_arbiter: directed vector table,
//            hand-written corner sequences and constrained-random traffic
//            against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_write_arbiter;

    logic        CLK;
    logic        RST;
    logic [2:0]  req;
    logic [5:0]  addr;
    logic [47:0] wdata;
    logic [2:0]  gnt;
    logic [3:0]  reg_load;
    logic [15:0] reg_in;
    logic        busy;
    logic [7:0]  wr_count;

    int n_tests = 0;
    int n_fail  = 0;

    reg_write_arbiter #(
        .WIDTH (16),
        .NREQ  (3),
        .NREG  (4)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .req      (req),
        .addr     (addr),
        .wdata    (wdata),
        .gnt      (gnt),
        .reg_load (reg_load),
        .reg_in   (reg_in),
        .busy     (busy),
        .wr_count (wr_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // External target registers, loaded by the arbiter's strobes
    logic [15:0] tregs [4] = '{default: 16'h0};
    always @(posedge CLK) begin
        for (int k = 0; k < 4; k++) begin
            if (reg_load[k]) tregs[k] <= reg_in;
        end
    end

    // ---------------- reference model (transaction level) -----------------
    bit          m_busy;
    int          m_last;
    int          m_cnt;
    logic [2:0]  m_gnt;
    logic [3:0]  m_load;
    logic [15:0] m_rin;
    int          m_waddr;
    logic [15:0] m_wdata;
    logic [15:0] m_regs [4] = '{default: 16'h0};

    task automatic model_reset();
        m_busy = 0; m_last = 2; m_cnt = 0;
        m_gnt = '0; m_load = '0; m_rin = '0;
    endtask

    // Predicts the outputs after the next edge from the inputs now applied
    task automatic model_step();
        if (m_busy) begin
            m_regs[m_waddr] = m_wdata;
            m_cnt  = (m_cnt + 1) % 256;
            m_busy = 0;
            m_gnt = '0; m_load = '0; m_rin = '0;
        end else if (req != 3'b000) begin
            for (int off = 1; off <= 3; off++) begin
                int i;
                i = (m_last + off) % 3;
                if (req[i]) begin
                    m_gnt   = 3'(1 << i);
                    m_waddr = int'((addr >> (2 * i)) & 6'd3);
                    m_wdata = 16'(wdata >> (16 * i));
                    m_load  = 4'(1 << m_waddr);
                    m_rin   = m_wdata;
                    m_busy  = 1;
                    m_last  = i;
                    break;
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] outs();
        return {32'h0, gnt, reg_load, reg_in, busy, wr_count};
    endfunction

    function automatic logic [63:0] m_outs();
        return {32'h0, m_gnt, m_load, m_rin, m_busy, 8'(m_cnt)};
    endfunction

    // One clock: predict, take the edge, compare outputs and register bank
    task automatic tick();
        model_step();
        @(posedge CLK);
        #1;
        chk("model_outs", outs(), m_outs());
        chk("model_regs", {tregs[3], tregs[2], tregs[1], tregs[0]},
                          {m_regs[3], m_regs[2], m_regs[1], m_regs[0]});
    endtask

    // Asynchronous reset pulse placed between clock edges
    task automatic do_reset();
        RST = 1'b1;
        #1;
        chk("async_reset", outs(), 64'h0);
        model_reset();
        RST = 1'b0;
        #1;
    endtask

    // ---------------- directed vector table --------------------------------
    typedef struct {
        bit          rst;
        logic [2:0]  req;
        logic [5:0]  addr;
        logic [47:0] wdata;
        logic [2:0]  gnt;
        logic [3:0]  load;
        logic [15:0] rin;
        logic        busy;
        logic [7:0]  cnt;
    } vec_t;

    vec_t vt [16];

    initial begin
        automatic logic [5:0]  a_s = 6'b00_00_10;
        automatic logic [47:0] w_s = {16'h0, 16'h0, 16'hBEEF};
        automatic logic [5:0]  a_c = 6'b11_01_00;
        automatic logic [47:0] w_c = {16'h3002, 16'h2001, 16'h1000};
        automatic bit pend [3];
        int grants;

        vt[0]  = '{0, 3'b001, a_s, w_s, 3'b001, 4'b0100, 16'hBEEF, 1, 8'd0};
        vt[1]  = '{0, 3'b000, a_s, w_s, 3'b000, 4'b0000, 16'h0000, 0, 8'd1};
        vt[2]  = '{1, 3'b111, a_c, w_c, 3'b001, 4'b0001, 16'h1000, 1, 8'd0};
        vt[3]  = '{0, 3'b110, a_c, w_c, 3'b000, 4'b0000, 16'h0000, 0, 8'd1};
        vt[4]  = '{0, 3'b110, a_c, w_c, 3'b010, 4'b0010, 16'h2001, 1, 8'd1};
        vt[5]  = '{0, 3'b100, a_c, w_c, 3'b000, 4'b0000, 16'h0000, 0, 8'd2};
        vt[6]  = '{0, 3'b100, a_c, w_c, 3'b100, 4'b1000, 16'h3002, 1, 8'd2};
        vt[7]  = '{0, 3'b000, a_c, w_c, 3'b000, 4'b0000, 16'h0000, 0, 8'd3};
        vt[8]  = '{0, 3'b011, a_c, w_c, 3'b001, 4'b0001, 16'h1000, 1, 8'd3};
        vt[9]  = '{0, 3'b011, a_c, w_c, 3'b000, 4'b0000, 16'h0000, 0, 8'd4};
        vt[10] = '{0, 3'b011, a_c, w_c, 3'b010, 4'b0010, 16'h2001, 1, 8'd4};
        vt[11] = '{0, 3'b011, a_c, w_c, 3'b000, 4'b0000, 16'h0000, 0, 8'd5};
        vt[12] = '{0, 3'b011, a_c, w_c, 3'b001, 4'b0001, 16'h1000, 1, 8'd5};
        vt[13] = '{0, 3'b011, a_c, w_c, 3'b000, 4'b0000, 16'h0000, 0, 8'd6};
        vt[14] = '{0, 3'b011, a_c, w_c, 3'b010, 4'b0010, 16'h2001, 1, 8'd6};
        vt[15] = '{0, 3'b000, a_c, w_c, 3'b000, 4'b0000, 16'h0000, 0, 8'd7};

        RST = 1'b1; req = '0; addr = '0; wdata = '0;
        model_reset();
        #2;
        chk("reset_state", outs(), 64'h0);
        @(posedge CLK);
        #1;
        chk("reset_held_over_edge", outs(), 64'h0);
        RST = 1'b0;
        #1;

        // Single write, contention and fairness from the table
        for (int i = 0; i < 16; i++) begin
            if (vt[i].rst) do_reset();
            req = vt[i].req; addr = vt[i].addr; wdata = vt[i].wdata;
            tick();
            chk($sformatf("vec%0d", i), outs(),
                {32'h0, vt[i].gnt, vt[i].load, vt[i].rin, vt[i].busy, vt[i].cnt});
        end
        chk("bank_after_table", {tregs[3], tregs[2], tregs[1], tregs[0]},
            {16'h3002, 16'hBEEF, 16'h2001, 16'h1000});

        // A request pulse that falls before the edge is ignored
        req = 3'b001;
        #2;
        req = 3'b000;
        tick();
        chk("pulse_no_grant", {61'h0, gnt}, 64'h0);

        // Inputs changing during WRITE do not reach the bus
        req = 3'b100; addr = 6'b01_00_00; wdata = {16'hABCD, 32'h0};
        tick();
        wdata = {16'h5555, 32'h0}; addr = 6'b00_00_00; req = 3'b000;
        #1;
        chk("write_holds_sample", {44'h0, reg_load, reg_in}, {44'h0, 4'b0010, 16'hABCD});
        tick();

        // Collision on register 3: earlier round-robin requester lands first
        do_reset();
        req = 3'b110; addr = 6'b11_11_00; wdata = {16'h2222, 16'h1111, 16'h0};
        tick();
        req = 3'b100;
        tick();
        chk("collision_first", {48'h0, tregs[3]}, 64'h1111);
        tick();
        req = 3'b000;
        tick();
        chk("collision_second", {48'h0, tregs[3]}, 64'h2222);

        // Reset during WRITE aborts the write and re-arms requester 0 priority
        do_reset();
        req = 3'b010; addr = 6'b00_00_00; wdata = {16'h0, 16'h7777, 16'h0};
        tick();
        req = 3'b000;
        #1;
        RST = 1'b1;
        #1;
        chk("abort_outputs", outs(), 64'h0);
        model_reset();
        RST = 1'b0;
        #1;
        req = 3'b011; addr = 6'b00_00_01; wdata = {16'h0, 16'h7777, 16'h4444};
        tick();
        chk("abort_bank_unchanged", {48'h0, tregs[0]}, 64'h1000);
        chk("abort_next_winner", {61'h0, gnt}, 64'h1);
        req = 3'b000;
        tick();

        // Constrained-random traffic honouring the hold-until-grant protocol
        do_reset();
        req = '0;
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (!pend[i] && $urandom_range(0, 3) == 0) begin
                    pend[i] = 1;
                    req[i] = 1'b1;
                    addr[2*i +: 2]   = 2'($urandom_range(0, 3));
                    wdata[16*i +: 16] = 16'($urandom);
                end
            end
            tick();
            for (int i = 0; i < 3; i++) begin
                if (m_gnt[i]) begin
                    if ($urandom_range(0, 1) == 0) begin
                        pend[i] = 0;
                        req[i] = 1'b0;
                    end else begin
                        addr[2*i +: 2]   = 2'($urandom_range(0, 3));
                        wdata[16*i +: 16] = 16'($urandom);
                    end
                end
            end
        end
        req = '0;
        tick();
        tick();

        // Counter wrap across 256 back-to-back writes
        do_reset();
        grants = 0;
        req = 3'b001;
        for (int c = 0; c < 512; c++) begin
            addr[1:0]  = 2'(c % 4);
            wdata[15:0] = 16'(c);
            tick();
            if (gnt[0]) grants++;
            if (c == 509) chk("wrap_255", {56'h0, wr_count}, 64'd255);
        end
        req = '0;
        chk("wrap_zero", {56'h0, wr_count}, 64'd0);
        chk("wrap_grants", 64'(grants), 64'd256);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: sim time %0t reached, limit 500000", $time);
        $fatal(1, "simulation did not terminate");
    end

endmodule
`default_nettype wire
